// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : two-master arbiter in front of the 1-cycle-latency data RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_LOCK      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_mode,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_mode,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] o_ram_addr,
  output logic [31:0] o_ram_wdata,
  output logic        o_ram_we,
  output logic [2:0]  o_ram_mode,
  input  logic [31:0] i_ram_rdata
);

  localparam int CW = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          last_gnt_q, last_gnt_d;
  logic          fair_q, fair_d;
  logic [1:0]    rvalid_q, rvalid_d;

  logic w_gnt0, w_gnt1, w_pick1;
  logic w_timeout;

  always_comb begin
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    w_pick1 = 1'b0;
    case (state_q)
      S_OWN0: w_gnt0 = m0_req;
      S_OWN1: w_gnt1 = m1_req;
      default: begin
        if (m0_req && m1_req) begin
          w_pick1 = (PRIORITY_MODE == 0) ? ~last_gnt_q : fair_q;
          w_gnt1  = w_pick1;
          w_gnt0  = ~w_pick1;
        end else begin
          w_gnt0 = m0_req;
          w_gnt1 = m1_req;
        end
      end
    endcase
  end

  // Grants are held low while reset is asserted, which also zeroes the RAM port.
  assign m0_gnt = w_gnt0 & rst;
  assign m1_gnt = w_gnt1 & rst;

  always_comb begin
    o_ram_addr  = 32'd0;
    o_ram_wdata = 32'd0;
    o_ram_we    = 1'b0;
    o_ram_mode  = 3'd0;
    if (m0_gnt) begin
      o_ram_addr  = m0_addr;
      o_ram_wdata = m0_wdata;
      o_ram_we    = m0_we;
      o_ram_mode  = m0_mode;
    end else if (m1_gnt) begin
      o_ram_addr  = m1_addr;
      o_ram_wdata = m1_wdata;
      o_ram_we    = m1_we;
      o_ram_mode  = m1_mode;
    end
  end

  assign w_timeout = (lock_cnt_q == CW'(MAX_LOCK - 1));

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_gnt_d = last_gnt_q;
    fair_d     = fair_q;
    if (m0_gnt) last_gnt_d = 1'b0;
    if (m1_gnt) begin
      last_gnt_d = 1'b1;
      fair_d     = 1'b0;
    end
    case (state_q)
      S_OWN0: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (w_timeout) begin
          state_d    = S_IDLE;
          last_gnt_d = 1'b0;
          fair_d     = 1'b1;
        end else if (!m0_lock) begin
          state_d = S_IDLE;
        end
      end
      S_OWN1: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (w_timeout) begin
          state_d    = S_IDLE;
          last_gnt_d = 1'b1;
          fair_d     = 1'b0;
        end else if (!m1_lock) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (m0_gnt && m0_lock) begin
          state_d    = S_OWN0;
          lock_cnt_d = '0;
        end else if (m1_gnt && m1_lock) begin
          state_d    = S_OWN1;
          lock_cnt_d = '0;
        end
      end
    endcase
  end

  assign rvalid_d = {m1_gnt & ~m1_we, m0_gnt & ~m0_we};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      lock_cnt_q <= '0;
      last_gnt_q <= 1'b1;
      fair_q     <= 1'b0;
      rvalid_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      last_gnt_q <= last_gnt_d;
      fair_q     <= fair_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = i_ram_rdata;
  assign m1_rdata  = i_ram_rdata;

endmodule

`default_nettype wire
